// File: rtl/delay_line_pkg.sv
// Shared types for the delay-line measurement slice.
// Holds the controller state encoding and a counter-width helper.
package delay_line_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ARM    = 3'd1,
      TRIG   = 3'd2,
      LISTEN = 3'd3,
      REPORT = 3'd4,
      HOLD   = 3'd5
   } meas_state_t;

   function automatic int cnt_w(input int max);
      return $clog2(max);
   endfunction

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter; done is high while the count is zero.
// Ports: clk, n_reset, load, load_val -> done.
module hold_timer #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         n_reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/delay_meas_ctrl.sv
// Delay-line measurement sequencer: trigger, listen, count, report.
// Ports: clk, n_reset, start, det_in, result_ready in;
//        busy, trig_out, det_n_reset, result_* out.
// Optional averaging over 2^AVG_LOG2 runs: define DELAY_MEAS_AVG_EN.
module delay_meas_ctrl
   import delay_line_pkg::*;
#(
   parameter  int MAX_CYCLES = 1024,
   parameter  int TRIG_LEN   = 4,
   parameter  int HOLDOFF    = 32,
   parameter  int AVG_LOG2   = 2,
   localparam int CNT_W      = cnt_w(MAX_CYCLES)
) (
   input  logic             clk,
   input  logic             n_reset,
   input  logic             start,
   output logic             busy,
   output logic             trig_out,
   output logic             det_n_reset,
   input  logic             det_in,
   output logic [CNT_W-1:0] result_data,
   output logic             result_timeout,
   output logic             result_valid,
   input  logic             result_ready
);

   localparam int TMAX = (HOLDOFF > TRIG_LEN) ? HOLDOFF : TRIG_LEN;
   localparam int TW   = cnt_w(TMAX) + 1;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CYCLES - 1);
   localparam logic [TW-1:0]    TRIG_LD = TW'(TRIG_LEN - 1);
   localparam logic [TW-1:0]    HOLD_LD = TW'(HOLDOFF - 1);

   if ((MAX_CYCLES & (MAX_CYCLES - 1)) != 0 || MAX_CYCLES < 8 ||
       TRIG_LEN < 1 || HOLDOFF < 1 || AVG_LOG2 < 0) begin : g_bad_cfg
      $error("delay_meas_ctrl: bad parameters");
   end

   meas_state_t      state;
   logic [CNT_W-1:0] cnt;
   logic             tmr_load;
   logic [TW-1:0]    tmr_val;
   logic             tmr_done;
   logic             hit;
   logic             ack;

   assign hit = (state == TRIG || state == LISTEN) && det_in;
   assign ack = (state == REPORT) && result_ready;

`ifdef DELAY_MEAS_AVG_EN
   localparam int ACC_W = CNT_W + AVG_LOG2;
   localparam logic [AVG_LOG2:0] RUN_LAST = (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1);

   logic [ACC_W-1:0]  acc;
   logic [ACC_W-1:0]  sum;
   logic [AVG_LOG2:0] run;
   logic              mid;

   assign sum = acc + ACC_W'(cnt);
   // An edge on any run but the last goes to HOLD instead of REPORT.
   assign mid = hit && (run != RUN_LAST);
   assign tmr_load = (state == ARM) || ack || mid;
`else
   assign tmr_load = (state == ARM) || ack;
`endif

   assign tmr_val = (state == ARM) ? TRIG_LD : HOLD_LD;

   hold_timer #(.W(TW)) u_tmr (
      .clk      (clk),
      .n_reset  (n_reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state          <= IDLE;
         cnt            <= '0;
         result_data    <= '0;
         result_timeout <= 1'b0;
         result_valid   <= 1'b0;
         trig_out       <= 1'b0;
         busy           <= 1'b0;
         det_n_reset    <= 1'b0;
`ifdef DELAY_MEAS_AVG_EN
         acc            <= '0;
         run            <= '0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  state       <= ARM;
                  busy        <= 1'b1;
                  det_n_reset <= 1'b1;
`ifdef DELAY_MEAS_AVG_EN
                  acc         <= '0;
                  run         <= '0;
`endif
               end
            end
            ARM: begin
               cnt      <= '0;
               state    <= TRIG;
               trig_out <= 1'b1;
            end
            TRIG, LISTEN: begin
               cnt <= cnt + CNT_W'(1);
               if (det_in) begin
                  trig_out <= 1'b0;
`ifdef DELAY_MEAS_AVG_EN
                  if (mid) begin
                     acc         <= sum;
                     run         <= run + 1'b1;
                     state       <= HOLD;
                     det_n_reset <= 1'b0;
                  end else begin
                     run            <= '0;
                     result_data    <= CNT_W'(sum >> AVG_LOG2);
                     result_timeout <= 1'b0;
                     result_valid   <= 1'b1;
                     state          <= REPORT;
                  end
`else
                  result_data    <= cnt;
                  result_timeout <= 1'b0;
                  result_valid   <= 1'b1;
                  state          <= REPORT;
`endif
               end else if (cnt == CNT_MAX) begin
                  trig_out       <= 1'b0;
                  result_data    <= CNT_MAX;
                  result_timeout <= 1'b1;
                  result_valid   <= 1'b1;
                  state          <= REPORT;
`ifdef DELAY_MEAS_AVG_EN
                  run            <= '0;
`endif
               end else if (state == TRIG && tmr_done) begin
                  trig_out <= 1'b0;
                  state    <= LISTEN;
               end
            end
            REPORT: begin
               if (result_ready) begin
                  result_valid <= 1'b0;
                  det_n_reset  <= 1'b0;
                  state        <= HOLD;
               end
            end
            HOLD: begin
               if (tmr_done) begin
`ifdef DELAY_MEAS_AVG_EN
                  // run is non-zero only between runs of one average.
                  if (run != '0) begin
                     state       <= ARM;
                     det_n_reset <= 1'b1;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
`else
                  state <= IDLE;
                  busy  <= 1'b0;
`endif
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_delay_meas_ctrl.sv
// Directed bench for delay_meas_ctrl with hand-computed expectations.
// Ports: drives every DUT port; prints one summary line.
module tb_delay_meas_ctrl;

   logic       clk = 1'b0;
   logic       n_reset = 1'b0;
   logic       start = 1'b0;
   logic       det_in = 1'b0;
   logic       result_ready = 1'b0;
   logic       busy;
   logic       trig_out;
   logic       det_n_reset;
   logic [9:0] result_data;
   logic       result_timeout;
   logic       result_valid;

   int n_chk = 0;
   int n_bad = 0;

   delay_meas_ctrl dut (
      .clk            (clk),
      .n_reset        (n_reset),
      .start          (start),
      .busy           (busy),
      .trig_out       (trig_out),
      .det_n_reset    (det_n_reset),
      .det_in         (det_in),
      .result_data    (result_data),
      .result_timeout (result_timeout),
      .result_valid   (result_valid),
      .result_ready   (result_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic ack_and_hold();
      int h;
      int cyc;
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      h = 0;
      cyc = 0;
      while (busy && cyc < 200) begin
         if (!det_n_reset) h++;
         @(negedge clk);
         cyc++;
      end
      check("hold_len", h, 32);
      check("busy_end", busy, 0);
   endtask

   // dly < 0: no edge. rdy_wait > 0: stall ready, pulse start inside.
   task automatic measure(input int dly, input int exp_data,
                          input int exp_to, input int exp_k,
                          input int exp_trig, input int rdy_wait);
      int lat;
      int k;
      int tc;
      int ok;
      pulse_start();
      lat = 1;
      while (!trig_out && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("trig_lat", lat, 2);
      k = 0;
      tc = 0;
      while (!result_valid && k < 1100) begin
         if (trig_out) tc++;
         det_in = (k == dly);
         @(negedge clk);
         k++;
      end
      det_in = 1'b0;
      check("edge_to_valid", k, exp_k);
      check("trig_len", tc, exp_trig);
      check("data", result_data, exp_data);
      check("timeout", result_timeout, exp_to);
      if (rdy_wait > 0) begin
         ok = 1;
         for (int i = 0; i < rdy_wait; i++) begin
            start = (i == 3);
            @(negedge clk);
            if (result_valid !== 1'b1 || result_data !== 10'(exp_data))
               ok = 0;
         end
         start = 1'b0;
         check("stall_stable", ok, 1);
      end
      ack_and_hold();
   endtask

`ifdef DELAY_MEAS_AVG_EN
   task automatic avg_run(input int dly);
      int w;
      int k;
      w = 0;
      while (!trig_out && w < 100) begin
         @(negedge clk);
         w++;
      end
      check("avg_trig", trig_out, 1);
      if (dly >= 0) begin
         for (int i = 0; i <= dly; i++) begin
            det_in = (i == dly);
            @(negedge clk);
         end
         det_in = 1'b0;
      end else begin
         k = 0;
         while (!result_valid && k < 1100) begin
            @(negedge clk);
            k++;
         end
      end
   endtask
`endif

   initial begin
      int tp;
      repeat (3) @(negedge clk);
      check("rst_flags",
            {busy, trig_out, result_valid, det_n_reset, result_timeout}, 0);
      check("rst_data", result_data, 0);
      n_reset = 1'b1;
      @(negedge clk);

`ifdef DELAY_MEAS_AVG_EN
      pulse_start();
      avg_run(10);
      avg_run(11);
      avg_run(12);
      avg_run(14);
      check("avg_valid", result_valid, 1);
      check("avg_data", result_data, 11);
      check("avg_to", result_timeout, 0);
      ack_and_hold();

      pulse_start();
      avg_run(10);
      avg_run(-1);
      check("avgto_valid", result_valid, 1);
      check("avgto_to", result_timeout, 1);
      check("avgto_data", result_data, 1023);
      ack_and_hold();
      tp = 0;
      for (int i = 0; i < 100; i++) begin
         if (trig_out) tp++;
         @(negedge clk);
      end
      check("avgto_no_trig", tp, 0);
`else
      // Edge 37 cycles after trigger.
      measure(37, 37, 0, 38, 4, 0);
      // No edge: timeout at the last count.
      measure(-1, 1023, 1, 1024, 4, 0);
      // Stalled consumer, start pulsed during REPORT.
      measure(20, 20, 0, 21, 4, 10);
      repeat (5) @(negedge clk);
      check("start_ignored", busy, 0);
      // Edge coincides with the final count: edge wins.
      measure(1023, 1023, 0, 1024, 4, 0);
      // Edge on the first trigger cycle.
      measure(0, 0, 0, 1, 1, 0);

      // Asynchronous abort during LISTEN.
      pulse_start();
      repeat (20) @(negedge clk);
      check("pre_rst_busy", busy, 1);
      #2 n_reset = 1'b0;
      #1;
      check("abort_flags",
            {busy, trig_out, result_valid, det_n_reset}, 0);
      @(negedge clk);
      n_reset = 1'b1;
      @(negedge clk);
      measure(5, 5, 0, 6, 4, 0);
      tp = 0;
`endif

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/delay_meas_ctrl.md
Name: delay_meas_ctrl

Overview:
Sequences one delay-line measurement. Fires a trigger pulse into the delay line, arms the rising-edge detector on the returned waveform, and counts clock cycles until the detector fires. Reports the count, or a timeout, on a valid/ready result interface. Sits between the system command logic and the delay line plus edge-detector pair.

Parameters:
MAX_CYCLES, 1024, listen window in cycles; CNT_W = $clog2(MAX_CYCLES); must be a power of two and at least 8.
TRIG_LEN, 4, trig_out high time in cycles; must be at least 1.
HOLDOFF, 32, dead cycles after each measurement; must exceed the edge detector TIMEOUT.
AVG_LOG2, 2, log2 of the number of measurements averaged per start; used only with DELAY_MEAS_AVG_EN.

Ports:
clk  in  1  system clock; all logic on the rising edge.
n_reset  in  1  asynchronous active-low reset.
start  in  1  request a measurement; sampled only in IDLE.
busy  out  1  high whenever the state is not IDLE.
trig_out  out  1  trigger pulse to the delay line input.
det_n_reset  out  1  active-low reset to the edge detector; low holds the detector cleared.
det_in  in  1  single-cycle pulse from the edge detector.
result_data  out  CNT_W  measured delay in cycles.
result_timeout  out  1  high when no edge was seen within the window.
result_valid  out  1  result available.
result_ready  in  1  consumer accepts the result.

Behaviour:
- Reset is asynchronous. While n_reset is low: state IDLE; counter, result_data and result_timeout are 0; trig_out, result_valid and busy are 0; det_n_reset is 0.
- States: IDLE, ARM, TRIG, LISTEN, REPORT, HOLD.
- det_n_reset is 0 in IDLE and HOLD, and 1 in all other states.
- IDLE: start=1 moves to ARM on the next clock. start in any other state is ignored; it is not queued.
- ARM: lasts 1 cycle, which lets the detector leave reset. Counter is cleared.
- TRIG: lasts TRIG_LEN cycles with trig_out=1. The counter is 0 on the first TRIG cycle and increments every cycle.
- LISTEN: trig_out=0 and the counter keeps incrementing.
- Delay definition: the number of clock edges from the first TRIG cycle to the cycle in which det_in=1. det_in on the first TRIG cycle gives 0.
- det_in=1 in TRIG or LISTEN: latch result_data = counter, set result_timeout=0, go to REPORT. det_in in any other state is ignored.
- Timeout: if the counter equals MAX_CYCLES-1 and det_in=0, latch result_data = MAX_CYCLES-1, set result_timeout=1, go to REPORT. If det_in=1 in that same cycle, the edge wins: timeout=0.
- REPORT: result_valid=1. result_data and result_timeout stay stable until result_valid and result_ready are both high in the same cycle. On that handshake, go to HOLD.
- result_ready is allowed high before valid; acceptance then happens in the first REPORT cycle.
- HOLD: lasts HOLDOFF cycles, then IDLE. result_data and result_timeout stay at their last values until the next REPORT.
- Latency: start to first trig_out = 2 cycles (IDLE→ARM→TRIG). Edge to result_valid = 1 cycle.
- Counter is CNT_W bits and never wraps; it saturates via the timeout rule.
- Reset asserted mid-measurement aborts immediately to the reset values above.

Optional Feature:
Macro: DELAY_MEAS_AVG_EN.
- Defined:
  - Each accepted start runs 2^AVG_LOG2 measurements. Each one is ARM→TRIG→LISTEN→HOLD; REPORT is skipped between runs.
  - Each delay is summed into a CNT_W+AVG_LOG2-bit accumulator, cleared on start.
  - After the last run, result_data = accumulator >> AVG_LOG2 (truncating), followed by REPORT and a final HOLD.
  - Any timeout aborts the remaining runs and goes straight to REPORT with result_timeout=1 and result_data = MAX_CYCLES-1.
- Undefined: one measurement per start; AVG_LOG2 is unused and no accumulator exists.

Decomposition:
- Package delay_line_pkg holds:
  - state enum meas_state_t, 3 bits;
  - function cnt_w(max) returning $clog2(max).
- Sub-module hold_timer: loadable down-counter with a done flag. It is reused for the TRIG_LEN and HOLDOFF intervals.
- The delay counter and the FSM remain in delay_meas_ctrl.

Test Plan:
1. Reset, then start=1 for 1 cycle; det_in pulses 37 cycles after the first trig_out cycle → result_data=37, result_timeout=0, result_valid one cycle after det_in. Also check trig_out is high exactly 4 cycles.
2. No det_in → result_valid with result_data=1023, result_timeout=1, exactly 1024 cycles after trig_out rises.
3. Hold result_ready=0 for 10 cycles in REPORT → data stable, valid held. Pulse start meanwhile → ignored. After ready, check 32 HOLD cycles with det_n_reset=0, then busy=0.
4. det_in coincident with the counter at 1023 → result_timeout=0, result_data=1023. det_in on the first TRIG cycle → result_data=0.
5. Assert n_reset low during LISTEN → trig_out, busy, result_valid and det_n_reset go 0 asynchronously. After release, a new start measures correctly.
6. With DELAY_MEAS_AVG_EN and AVG_LOG2=2, delays 10, 11, 12, 14 → result_data=11 after 4 runs. A timeout on run 2 → result_timeout=1 with no further trig pulses.
